// File: rtl/loop_nest_ctrl_if.sv
// Beat/control bundle between the loop-nest sequencer (master) and its datapath/host (slave).
// Signal names follow the block's external pin names.
interface loop_nest_ctrl_if #(parameter int CNT_WIDTH = 8);
    logic                 startIn;
    logic                 abortIn;
    logic [CNT_WIDTH-1:0] rowsIn;
    logic [CNT_WIDTH-1:0] colsIn;
    logic [CNT_WIDTH-1:0] depthIn;
    logic                 readyIn;
    logic                 validOut;
    logic [CNT_WIDTH-1:0] rowOut;
    logic [CNT_WIDTH-1:0] colOut;
    logic [CNT_WIDTH-1:0] kOut;
    logic                 kFirstOut;
    logic                 kLastOut;
    logic                 busyOut;
    logic                 doneOut;

    modport master (
        input  startIn, abortIn, rowsIn, colsIn, depthIn, readyIn,
        output validOut, rowOut, colOut, kOut, kFirstOut, kLastOut, busyOut, doneOut
    );

    modport slave (
        output startIn, abortIn, rowsIn, colsIn, depthIn, readyIn,
        input  validOut, rowOut, colOut, kOut, kFirstOut, kLastOut, busyOut, doneOut
    );
endinterface

// File: rtl/loop_nest_ctrl.sv
// 3-deep loop-nest sequencer (r outer, c, k inner) issuing one index beat per accepted cycle,
// with first/last-k flags for accumulator clear and write-back.

// Index counter: clear wins over advance; advancing at the end value wraps to 0.
module loop_idx_cnt #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         adv_i,
    input  logic [W-1:0] last_i,
    output logic [W-1:0] cnt_o,
    output logic         at_end_o
);
    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    assign at_end_o = (cnt_q == last_i);
    assign cnt_o    = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (adv_i)
            cnt_d = at_end_o ? '0 : cnt_q + ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

module loop_nest_ctrl #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    loop_nest_ctrl_if.master     bus
);
    localparam int NLVL = 3;  // 0 = k, 1 = c, 2 = r
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [NLVL-1:0][CNT_WIDTH-1:0] bound_q, bound_d;
    logic [NLVL-1:0][CNT_WIDTH-1:0] last_q, last_d;
    logic [NLVL-1:0][CNT_WIDTH-1:0] idx;
    logic [NLVL-1:0]                at_end;
    logic [NLVL-1:0]                adv;

    logic start_acc, xfer, final_beat, any_zero;

    assign start_acc  = (state_q == S_IDLE) && bus.startIn && !bus.abortIn;
    assign xfer       = (state_q == S_RUN) && bus.readyIn && !bus.abortIn;
    assign final_beat = &at_end;
    assign any_zero   = (bound_q[0] == '0) || (bound_q[1] == '0) || (bound_q[2] == '0);

    // Odometer carry chain; the final beat freezes all indices at their end values.
    assign adv[0] = xfer && !final_beat;
    assign adv[1] = xfer && !final_beat && at_end[0];
    assign adv[2] = xfer && !final_beat && at_end[0] && at_end[1];

    for (genvar g = 0; g < NLVL; g++) begin : g_lvl
        loop_idx_cnt #(.W(CNT_WIDTH)) u_cnt (
            .clk_i    (clkIn),
            .rst_i    (rstIn),
            .clr_i    (start_acc),
            .adv_i    (adv[g]),
            .last_i   (last_q[g]),
            .cnt_o    (idx[g]),
            .at_end_o (at_end[g])
        );
    end

    always_comb begin
        state_d = state_q;
        bound_d = bound_q;
        last_d  = last_q;
        case (state_q)
            S_IDLE: if (start_acc) begin
                state_d = S_LOAD;
                bound_d = {bus.rowsIn, bus.colsIn, bus.depthIn};
            end
            S_LOAD: begin
                state_d = any_zero ? S_DONE : S_RUN;
                // Underflow on a zero bound is harmless: that nest never reaches RUN.
                for (int i = 0; i < NLVL; i++)
                    last_d[i] = bound_q[i] - ONE;
            end
            S_RUN:  if (xfer && final_beat) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.abortIn && state_q != S_IDLE)
            state_d = S_IDLE;
    end

    always_ff @(posedge clkIn) begin
        if (rstIn) begin
            state_q <= S_IDLE;
            bound_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            bound_q <= bound_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        bus.validOut  = (state_q == S_RUN);
        bus.busyOut   = (state_q != S_IDLE);
        bus.doneOut   = (state_q == S_DONE);
        bus.rowOut    = idx[2];
        bus.colOut    = idx[1];
        bus.kOut      = idx[0];
        bus.kFirstOut = bus.validOut && (idx[0] == '0);
        bus.kLastOut  = bus.validOut && at_end[0];
    end
endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Directed bench for loop_nest_ctrl: nest ordering, flags, stalls, abort, restart and bound edges.
module tb_loop_nest_ctrl;
    logic clkIn;
    logic rstIn;
    int   checks   = 0;
    int   failures = 0;

    loop_nest_ctrl_if #(.CNT_WIDTH(8)) bus();

    loop_nest_ctrl #(.CNT_WIDTH(8)) dut (
        .clkIn (clkIn),
        .rstIn (rstIn),
        .bus   (bus.master)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    // {valid,row,col,k,kFirst,kLast} and {busy,valid,done}
    logic [26:0] beat_obs;
    logic [2:0]  ctl_obs;
    assign beat_obs = {bus.validOut, bus.rowOut, bus.colOut, bus.kOut, bus.kFirstOut, bus.kLastOut};
    assign ctl_obs  = {bus.busyOut, bus.validOut, bus.doneOut};

    task automatic tick;
        @(posedge clkIn);
        #1;
    endtask

    // Start is held for one cycle t; returns in cycle t+1 with the bound inputs scrambled.
    task automatic do_start(input logic [7:0] r, input logic [7:0] c, input logic [7:0] k);
        bus.rowsIn  = r;
        bus.colsIn  = c;
        bus.depthIn = k;
        bus.startIn = 1'b1;
        tick();
        bus.startIn = 1'b0;
        bus.rowsIn  = 8'hA5;
        bus.colsIn  = 8'h5A;
        bus.depthIn = 8'h33;
    endtask

    task automatic test_reset;
        rstIn = 1'b1;
        tick();
        tick();
        checks++;
        if ({beat_obs, ctl_obs} !== 30'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", {beat_obs, ctl_obs});
        end
        rstIn = 1'b0;
        tick();
        checks++;
        if ({beat_obs, ctl_obs} !== 30'd0) begin
            failures++;
            $display("FAIL idle_after_reset got=%h exp=0", {beat_obs, ctl_obs});
        end
    endtask

    task automatic test_basic_nest;
        logic [26:0] exp;
        do_start(8'd2, 8'd3, 8'd4);
        checks++;
        if (ctl_obs !== 3'b100) begin
            failures++;
            $display("FAIL basic_load got=%b exp=100", ctl_obs);
        end
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 3; c++)
                for (int k = 0; k < 4; k++) begin
                    tick();
                    exp = {1'b1, 8'(r), 8'(c), 8'(k), (k == 0), (k == 3)};
                    checks++;
                    if (beat_obs !== exp) begin
                        failures++;
                        $display("FAIL basic_beat r%0d c%0d k%0d got=%h exp=%h", r, c, k, beat_obs, exp);
                    end
                end
        tick();
        checks++;
        if (ctl_obs !== 3'b101) begin
            failures++;
            $display("FAIL basic_done got=%b exp=101", ctl_obs);
        end
        tick();
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL basic_idle got=%b exp=000", ctl_obs);
        end
    endtask

    task automatic test_single;
        do_start(8'd1, 8'd1, 8'd1);
        checks++;
        if (ctl_obs !== 3'b100) begin
            failures++;
            $display("FAIL single_load got=%b exp=100", ctl_obs);
        end
        tick();
        checks++;
        if ({beat_obs, bus.busyOut} !== {1'b1, 24'd0, 2'b11, 1'b1}) begin
            failures++;
            $display("FAIL single_beat got=%h exp=%h", {beat_obs, bus.busyOut}, {1'b1, 24'd0, 2'b11, 1'b1});
        end
        tick();
        checks++;
        if (ctl_obs !== 3'b101) begin
            failures++;
            $display("FAIL single_done got=%b exp=101", ctl_obs);
        end
        tick();
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL single_idle got=%b exp=000", ctl_obs);
        end
    endtask

    task automatic test_zero_bound;
        do_start(8'd3, 8'd0, 8'd5);
        checks++;
        if (ctl_obs !== 3'b100) begin
            failures++;
            $display("FAIL zero_load got=%b exp=100", ctl_obs);
        end
        tick();
        checks++;
        if (ctl_obs !== 3'b101) begin
            failures++;
            $display("FAIL zero_done got=%b exp=101", ctl_obs);
        end
        tick();
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL zero_idle got=%b exp=000", ctl_obs);
        end
    endtask

    task automatic test_stall;
        logic [26:0] seq [4];
        int xfers = 0;
        int stalls = 0;
        seq[0] = {1'b1, 8'd0, 8'd0, 8'd0, 2'b10};
        seq[1] = {1'b1, 8'd0, 8'd0, 8'd1, 2'b01};
        seq[2] = {1'b1, 8'd0, 8'd1, 8'd0, 2'b10};
        seq[3] = {1'b1, 8'd0, 8'd1, 8'd1, 2'b01};
        bus.readyIn = 1'b0;
        do_start(8'd1, 8'd2, 8'd2);
        for (int cyc = 0; cyc < 40 && xfers < 4; cyc++) begin
            tick();
            bus.readyIn = cyc[0];
            if (bus.validOut) begin
                checks++;
                if (beat_obs !== seq[xfers]) begin
                    failures++;
                    $display("FAIL stall_beat n%0d got=%h exp=%h", xfers, beat_obs, seq[xfers]);
                end
                if (bus.readyIn) xfers++;
                else stalls++;
            end
        end
        checks++;
        if (xfers != 4 || stalls == 0) begin
            failures++;
            $display("FAIL stall_count got=%0d xfers %0d stalls exp=4 xfers >0 stalls", xfers, stalls);
        end
        bus.readyIn = 1'b1;
        tick();
        checks++;
        if (ctl_obs !== 3'b101) begin
            failures++;
            $display("FAIL stall_done got=%b exp=101", ctl_obs);
        end
        tick();
    endtask

    task automatic test_abort_restart;
        logic [26:0] exp;
        logic saw_done = 1'b0;
        do_start(8'd4, 8'd4, 8'd4);
        for (int e = 0; e <= 10; e++) begin
            tick();
            exp = {1'b1, 8'(e / 16), 8'((e / 4) % 4), 8'(e % 4), (e % 4 == 0), (e % 4 == 3)};
            checks++;
            if (beat_obs !== exp) begin
                failures++;
                $display("FAIL abort_beat n%0d got=%h exp=%h", e, beat_obs, exp);
            end
        end
        bus.abortIn = 1'b1;
        tick();
        bus.abortIn = 1'b0;
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL abort_idle got=%b exp=000", ctl_obs);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.doneOut || bus.validOut) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done got=%b exp=0", saw_done);
        end
        do_start(8'd1, 8'd1, 8'd1);
        tick();
        checks++;
        if (beat_obs !== {1'b1, 24'd0, 2'b11}) begin
            failures++;
            $display("FAIL restart_beat got=%h exp=%h", beat_obs, {1'b1, 24'd0, 2'b11});
        end
        tick();
        checks++;
        if (ctl_obs !== 3'b101) begin
            failures++;
            $display("FAIL restart_done got=%b exp=101", ctl_obs);
        end
        tick();
    endtask

    task automatic test_start_abort_idle;
        bus.rowsIn  = 8'd1;
        bus.colsIn  = 8'd1;
        bus.depthIn = 8'd1;
        bus.startIn = 1'b1;
        bus.abortIn = 1'b1;
        tick();
        bus.startIn = 1'b0;
        bus.abortIn = 1'b0;
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL start_abort_t1 got=%b exp=000", ctl_obs);
        end
        tick();
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL start_abort_t2 got=%b exp=000", ctl_obs);
        end
    endtask

    task automatic test_start_ignored;
        logic [26:0] exp;
        do_start(8'd1, 8'd1, 8'd3);
        for (int k = 0; k < 3; k++) begin
            tick();
            if (k == 0) begin
                bus.rowsIn  = 8'd5;
                bus.colsIn  = 8'd5;
                bus.depthIn = 8'd5;
                bus.startIn = 1'b1;
            end else begin
                bus.startIn = 1'b0;
            end
            exp = {1'b1, 8'd0, 8'd0, 8'(k), (k == 0), (k == 2)};
            checks++;
            if (beat_obs !== exp) begin
                failures++;
                $display("FAIL ignstart_beat k%0d got=%h exp=%h", k, beat_obs, exp);
            end
        end
        tick();
        bus.startIn = 1'b1;
        checks++;
        if (ctl_obs !== 3'b101) begin
            failures++;
            $display("FAIL ignstart_done got=%b exp=101", ctl_obs);
        end
        tick();
        bus.startIn = 1'b0;
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL ignstart_no_restart got=%b exp=000", ctl_obs);
        end
        tick();
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL ignstart_still_idle got=%b exp=000", ctl_obs);
        end
    endtask

    task automatic test_mid_reset;
        do_start(8'd2, 8'd2, 8'd2);
        tick();
        tick();
        tick();
        rstIn = 1'b1;
        tick();
        checks++;
        if ({beat_obs, ctl_obs} !== 30'd0) begin
            failures++;
            $display("FAIL midreset_outputs got=%h exp=0", {beat_obs, ctl_obs});
        end
        rstIn = 1'b0;
        tick();
        checks++;
        if (ctl_obs !== 3'b000) begin
            failures++;
            $display("FAIL midreset_idle got=%b exp=000", ctl_obs);
        end
    endtask

    task automatic test_max_bound;
        logic [26:0] exp;
        do_start(8'd1, 8'd1, 8'd255);
        for (int k = 0; k < 255; k++) begin
            tick();
            exp = {1'b1, 8'd0, 8'd0, 8'(k), (k == 0), (k == 254)};
            checks++;
            if (beat_obs !== exp) begin
                failures++;
                $display("FAIL max_beat k%0d got=%h exp=%h", k, beat_obs, exp);
            end
        end
        tick();
        checks++;
        if ({ctl_obs, bus.kOut} !== {3'b101, 8'd254}) begin
            failures++;
            $display("FAIL max_done_hold got=%h exp=%h", {ctl_obs, bus.kOut}, {3'b101, 8'd254});
        end
        tick();
    endtask

    initial begin
        rstIn       = 1'b1;
        bus.startIn = 1'b0;
        bus.abortIn = 1'b0;
        bus.rowsIn  = '0;
        bus.colsIn  = '0;
        bus.depthIn = '0;
        bus.readyIn = 1'b1;
        test_reset();
        test_basic_nest();
        test_single();
        test_zero_bound();
        test_stall();
        test_abort_restart();
        test_start_abort_idle();
        test_start_ignored();
        test_mid_reset();
        test_max_bound();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end
endmodule
